muxnlut_reg: RTL and testbench

MUXNLUT_REG -- requirements
Module: muxnlut_reg

---
 rtl/muxnlut_pkg.sv | 27 ++
 rtl/cus_mux21_buf.sv | 11 +
 rtl/muxnlut_reg.sv | 103 ++++++++++
 tb/tb_muxnlut_reg.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/muxnlut_pkg.sv
// Shared constants and config-bit index helpers for the muxnlut_reg mux tree.
package muxnlut_pkg;

  localparam int LEVELS_MAX = 5;

  function automatic int no_config_bits(input int levels);
    return 2 * levels - 1;
  endfunction

  // REG_k: output k is taken from its register instead of the combinational tree.
  function automatic int reg_idx(input int k);
    return k - 1;
  endfunction

  // SPLIT_k: level k selects from the upper window I[2**k .. 2**(k+1)-1].
  function automatic int split_idx(input int levels, input int k);
    return levels + k - 1;
  endfunction

  function automatic int flog2(input int n);
    int r;
    r = 0;
    for (int v = n; v > 1; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/cus_mux21_buf.sv
// Buffered 2:1 mux cell: X = S ? A1 : A0.
module cus_mux21_buf (
  input  logic A0,
  input  logic A1,
  input  logic S,
  output logic X
);

  assign X = S ? A1 : A0;

endmodule

// File: rtl/muxnlut_reg.sv
// Multi-level mux tree with per-level optional output registers.
// Define MUXNLUT_PIPE_EN to add a CE-gated input register stage on I and S.
module muxnlut_reg
  import muxnlut_pkg::*;
#(
  parameter int LEVELS       = 3,
  parameter int NoConfigBits = no_config_bits(LEVELS)
) (
  input  logic                    UserCLK,
  input  logic                    resetn,
  input  logic [2**LEVELS-1:0]    I,
  input  logic [LEVELS-1:0]       S,
  input  logic                    CE,
  input  logic                    SR,
  output logic [LEVELS-1:0]       M,
  input  logic [NoConfigBits-1:0] ConfigBits
);

  localparam int N_IN = 2**LEVELS;

  logic [N_IN-1:0]   i_eff;
  logic [LEVELS-1:0] s_eff;
  logic [LEVELS-1:0] c;
  logic [LEVELS-1:0] out_q, out_d;

`ifdef MUXNLUT_PIPE_EN
  logic [N_IN-1:0]   i_q, i_d;
  logic [LEVELS-1:0] s_q, s_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    i_d = i_q;
    s_d = s_q;
    if (CE) begin
      i_d = I;
      s_d = S;
    end
  end

  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) begin
      i_q <= '0;
      s_q <= '0;
    end else begin
      i_q <= i_d;
      s_q <= s_d;
    end
  end

  assign i_eff = i_q;
  assign s_eff = s_q;
`else
  assign i_eff = I;
  assign s_eff = S;
`endif

  // Heap-ordered tree: node 1 is the root, leaves node[N_IN+i] = I[i],
  // and node n at depth d selects with S[LEVELS-1-d].
  logic [2*N_IN-1:1] node;
  assign node[2*N_IN-1:N_IN] = i_eff;

  for (genvar n = 1; n < N_IN; n++) begin : g_node
    localparam int DEPTH = flog2(n);
    cus_mux21_buf u_mux (
      .A0 (node[2*n]),
      .A1 (node[2*n+1]),
      .S  (s_eff[LEVELS-1-DEPTH]),
      .X  (node[n])
    );
  end

  // The two leftmost subtrees at depth LEVELS-k cover the lower and upper
  // 2**k-input windows; SPLIT_k picks between them.
  for (genvar k = 1; k <= LEVELS; k++) begin : g_level
    if (k == LEVELS) begin : g_top
      assign c[k-1] = node[1];
    end else begin : g_split
      cus_mux21_buf u_split (
        .A0 (node[2**(LEVELS-k)]),
        .A1 (node[2**(LEVELS-k)+1]),
        .S  (ConfigBits[split_idx(LEVELS, k)]),
        .X  (c[k-1])
      );
    end
  end

  always_comb begin
    out_d = out_q;
    if (SR)      out_d = '0;
    else if (CE) out_d = c;
  end

  // NOTE: sequential state uses non-blocking assignments; reset is async active-low.
  always_ff @(posedge UserCLK or negedge resetn) begin
    if (!resetn) out_q <= '0;
    else         out_q <= out_d;
  end

  for (genvar k = 1; k <= LEVELS; k++) begin : g_out
    assign M[k-1] = ConfigBits[reg_idx(k)] ? out_q[k-1] : c[k-1];
  end

endmodule

// File: tb/tb_muxnlut_reg.sv
// Self-checking bench for muxnlut_reg (LEVELS=3): directed scenarios plus
// randomized stimulus against a behavioural window-index model.
module tb_muxnlut_reg;

  localparam int L = 3;
`ifdef MUXNLUT_PIPE_EN
  localparam int PIPE = 1;
`else
  localparam int PIPE = 0;
`endif

  logic         UserCLK;
  logic         resetn;
  logic [7:0]   I;
  logic [2:0]   S;
  logic         CE;
  logic         SR;
  logic [2:0]   M;
  logic [4:0]   cfg;

  int n_tests;
  int n_fail;

  // Reference state: registered outputs and the optional input stage.
  logic [2:0] mq;
  logic [7:0] pi;
  logic [2:0] ps;

  muxnlut_reg #(.LEVELS(3), .NoConfigBits(5)) dut (
    .UserCLK    (UserCLK),
    .resetn     (resetn),
    .I          (I),
    .S          (S),
    .CE         (CE),
    .SR         (SR),
    .M          (M),
    .ConfigBits (cfg)
  );

  initial UserCLK = 1'b0;
  always #5 UserCLK = ~UserCLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Level k reads I[base + (S mod 2**k)], base = 2**k when SPLIT_k is set.
  function automatic logic [2:0] comb_vec();
    logic [7:0] ie;
    logic [2:0] se;
    logic [2:0] r;
    int idx;
    ie = (PIPE != 0) ? pi : I;
    se = (PIPE != 0) ? ps : S;
    r = '0;
    for (int k = 1; k <= L; k++) begin
      idx = 0;
      if (k < L) begin
        if (cfg[L+k-1]) idx = 1 << k;
      end
      idx = idx + (int'(se) % (1 << k));
      r[k-1] = ie[idx];
    end
    return r;
  endfunction

  function automatic logic [2:0] exp_m();
    logic [2:0] cv;
    logic [2:0] r;
    cv = comb_vec();
    for (int k = 0; k < L; k++) r[k] = cfg[k] ? mq[k] : cv[k];
    return r;
  endfunction

  task automatic model_reset();
    mq = '0;
    pi = '0;
    ps = '0;
  endtask

  task automatic model_edge();
    logic [2:0] cv;
    if (!resetn) begin
      model_reset();
    end else begin
      cv = comb_vec();
      if (SR)      mq = '0;
      else if (CE) mq = cv;
      if (CE) begin
        pi = I;
        ps = S;
      end
    end
  endtask

  task automatic tick();
    @(posedge UserCLK);
    model_edge();
    #1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    resetn = 1'b0;
    I = '0; S = '0; CE = 1'b0; SR = 1'b0; cfg = '0;
    model_reset();

    // Reset: registered outputs read 0, combinational ones stay live.
    tick(); tick();
    check("reset_comb", 32'(M), 32'd0);
    @(negedge UserCLK);
    cfg = 5'b00111; I = 8'hFF; S = 3'd7; CE = 1'b1;
    #1 check("reset_all_reg", 32'(M), 32'd0);
    cfg = 5'b00011;
    #1 check("reset_top_comb", 32'(M), (PIPE != 0) ? 32'd0 : 32'd4);
    @(negedge UserCLK);
    resetn = 1'b1;

    // Scenario: no split, all combinational.
    @(negedge UserCLK);
    cfg = 5'b00000; I = 8'b1010_0110; S = 3'd5; CE = 1'b1; SR = 1'b0;
    repeat (PIPE) tick();
    #1 check("d1_comb", 32'(M), 32'b111);

    // Scenario: split windows on levels 1 and 2.
    @(negedge UserCLK);
    cfg = 5'b11000; I = 8'hF0; S = 3'd2;
    repeat (PIPE) tick();
    #1 check("d2_split", 32'(M), 32'b010);

    // Scenario: registered top level, capture then hold with CE=0.
    @(negedge UserCLK);
    cfg = 5'b00100; I = 8'h00; S = 3'd7; CE = 1'b1;
    tick(); tick();
    @(negedge UserCLK);
    I = 8'h80;
    #1 check("d3_before", 32'(M[2]), 32'd0);
    tick();
`ifdef MUXNLUT_PIPE_EN
    check("d3_pipe_wait", 32'(M[2]), 32'd0);
    tick();
`endif
    check("d3_after", 32'(M[2]), 32'd1);
    @(negedge UserCLK);
    CE = 1'b0; I = 8'h00;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("d3_hold", 32'(M[2]), 32'd1);
    end

    // Scenario: synchronous clear beats and ignores CE.
    @(negedge UserCLK);
    SR = 1'b1; CE = 1'b0;
    tick();
    check("d4_sr", 32'(M[2]), 32'd0);
    @(negedge UserCLK);
    SR = 1'b0; CE = 1'b1; I = 8'h80;
    tick();
    check("d4_reload", 32'(M[2]), 32'd1);
    @(negedge UserCLK);
    SR = 1'b1; CE = 1'b1;
    tick();
    check("d4_sr_ce", 32'(M[2]), 32'd0);

    // Scenario: asynchronous reset between edges, then release with CE=1.
    @(negedge UserCLK);
    SR = 1'b0; CE = 1'b1; I = 8'h80;
    tick(); tick();
    check("d5_pre", 32'(M[2]), 32'd1);
    #2 resetn = 1'b0;
    model_reset();
    #1 check("d5_async", 32'(M[2]), 32'd0);
    @(negedge UserCLK);
    resetn = 1'b1;
    tick();
    check("d5_release", 32'(M[2]), (PIPE != 0) ? 32'd0 : 32'd1);
`ifdef MUXNLUT_PIPE_EN
    tick();
    check("d5_release_pipe", 32'(M[2]), 32'd1);
`endif

    // Scenario: step response latency, registered then combinational.
    @(negedge UserCLK);
    cfg = 5'b00100; I = 8'h00; S = 3'd7; CE = 1'b1;
    tick(); tick();
    @(negedge UserCLK);
    I = 8'hFF;
    #1 check("d6_reg_pre", 32'(M[2]), 32'd0);
    tick();
    check("d6_reg_e1", 32'(M[2]), (PIPE != 0) ? 32'd0 : 32'd1);
    tick();
    check("d6_reg_e2", 32'(M[2]), 32'd1);
    @(negedge UserCLK);
    cfg = 5'b00000; I = 8'h00;
    tick(); tick();
    @(negedge UserCLK);
    I = 8'hFF;
    #1 check("d6_comb_pre", 32'(M[2]), (PIPE != 0) ? 32'd0 : 32'd1);
    tick();
    check("d6_comb_e1", 32'(M[2]), 32'd1);

    // Randomized traffic with runtime config changes and occasional async reset.
    for (int it = 0; it < 400; it++) begin
      @(negedge UserCLK);
      resetn = 1'b1;
      I  = 8'($urandom);
      S  = 3'($urandom_range(0, 7));
      CE = ($urandom_range(0, 3) != 0);
      SR = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) cfg = 5'($urandom);
      #1 check("rand_comb", 32'(M), 32'(exp_m()));
      tick();
      check("rand_edge", 32'(M), 32'(exp_m()));
      if ($urandom_range(0, 19) == 0) begin
        #2 resetn = 1'b0;
        model_reset();
        #1 check("rand_async_rst", 32'(M), 32'(exp_m()));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
